// File: rtl/instr_cache_fill_ctrl.sv
// Instruction-cache line-fill controller: 4-beat burst read, line assembly, single full-mask SRAM + tag write.
// Optional ICACHE_FILL_BYPASS_EN forwards the assembled line on bypass_line during DONE.
module instr_cache_fill_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int SET_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   miss_req,
  input  logic [ADDR_WIDTH-1:0]  miss_addr,
  output logic                   miss_ready,
  output logic                   fill_done,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [BEAT_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_resp,
  output logic                   sram_csb0,
  output logic                   sram_web0,
  output logic [DATA_WIDTH/8-1:0] sram_wmask0,
  output logic [SET_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]  sram_din0,
  output logic                   tag_we,
  output logic [SET_WIDTH-1:0]   tag_index,
  output logic [ADDR_WIDTH-SET_WIDTH-$clog2(DATA_WIDTH/8)-1:0] tag_wdata,
  output logic                   bypass_valid,
  output logic [DATA_WIDTH-1:0]  bypass_line,
  output logic [1:0]             fsm_state
);

  localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] line;
  logic [CNT_W-1:0]      beat_cnt;
  logic [DATA_WIDTH-1:0] buffer;
  logic                  accept;
  logic                  beat_take;
  logic                  unused_offset;

  assign accept        = miss_req && (state == IDLE);
  assign beat_take     = mem_resp && (state == RECV);
  assign fsm_state     = state;
  // Offset bits are latched but never used: the burst always starts at the line base.
  assign unused_offset = ^line[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      line     <= '0;
      beat_cnt <= '0;
      buffer   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        line     <= miss_addr;
        beat_cnt <= '0;
      end
      if (beat_take) begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat_cnt == CNT_W'(b)) buffer[b*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
        end
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_addr = {line[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    state_next   = state;
    miss_ready   = 1'b0;
    fill_done    = 1'b0;
    mem_read     = 1'b0;
    sram_csb0    = 1'b1;
    sram_web0    = 1'b1;
    sram_wmask0  = '0;
    sram_addr0   = '0;
    sram_din0    = '0;
    tag_we       = 1'b0;
    tag_index    = '0;
    tag_wdata    = '0;
    bypass_valid = 1'b0;
    bypass_line  = '0;
    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_req) state_next = RECV;
      end
      RECV: begin
        mem_read = 1'b1;
        if (mem_resp && (beat_cnt == CNT_W'(BEATS - 1))) state_next = WRITE;
      end
      WRITE: begin
        // The fetch path must not use the SRAM port in this cycle.
        sram_csb0   = 1'b0;
        sram_web0   = 1'b0;
        sram_wmask0 = '1;
        sram_addr0  = line[OFF_W +: SET_WIDTH];
        sram_din0   = buffer;
        tag_we      = 1'b1;
        tag_index   = line[OFF_W +: SET_WIDTH];
        tag_wdata   = line[ADDR_WIDTH-1:OFF_W+SET_WIDTH];
        state_next  = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
`ifdef ICACHE_FILL_BYPASS_EN
        bypass_valid = 1'b1;
        bypass_line  = buffer;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_cache_fill_ctrl.sv
// Directed bench for instr_cache_fill_ctrl: fills, gapped beats, strays, back-to-back misses, reset mid-burst.
module tb_instr_cache_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         fill_done;
  logic         mem_read;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_rdata;
  logic         mem_resp;
  logic         sram_csb0;
  logic         sram_web0;
  logic [31:0]  sram_wmask0;
  logic [3:0]   sram_addr0;
  logic [255:0] sram_din0;
  logic         tag_we;
  logic [3:0]   tag_index;
  logic [22:0]  tag_wdata;
  logic         bypass_valid;
  logic [255:0] bypass_line;
  logic [1:0]   fsm_state;

  int           cyc = 0;
  int           n_vec = 0;
  int           n_bad = 0;
  int           n_wr = 0;
  int           last_acc = 0;
  int           last_done = 0;
  logic         bp_seen = 1'b0;
  logic [282:0] exp_q[$];
  logic [255:0] sram_mem[16];

  instr_cache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .fill_done(fill_done), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0), .tag_we(tag_we),
    .tag_index(tag_index), .tag_wdata(tag_wdata), .bypass_valid(bypass_valid),
    .bypass_line(bypass_line), .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every SRAM write must match the oldest pending fill
  always @(negedge clk) begin
    if (rst_n) begin
      if (bypass_valid) bp_seen <= 1'b1;
      check("tag_we_vs_csb", tag_we, !sram_csb0);
      check("web_vs_csb", sram_web0, sram_csb0);
      if (!sram_csb0) begin
        logic [282:0] e;
        n_wr++;
        check("write_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sram_din0", sram_din0, e[255:0]);
          check("sram_addr0", sram_addr0, e[259:256]);
          check("sram_wmask0", sram_wmask0, 32'hFFFF_FFFF);
          check("tag_index", tag_index, e[259:256]);
          check("tag_wdata", tag_wdata, e[282:260]);
        end
        sram_mem[sram_addr0] = sram_din0;
      end
    end
  end

  task automatic do_fill(input logic [31:0] addr, input logic [63:0] base, input int gap,
                         input bit hold, input bit stray_done);
    logic [255:0] line;
    int n;
    for (int k = 0; k < 4; k++) line[k*64 +: 64] = base + 64'(k);
    exp_q.push_back({addr[31:9], addr[8:5], line});
    miss_addr = addr;
    miss_req  = 1'b1;
    n = 0;
    while (!miss_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_wait", miss_ready, 1'b1);
    last_acc = cyc;
    @(posedge clk); #1;
    if (!hold) miss_req = 1'b0;
    check("mem_read_rise", mem_read, 1'b1);
    check("mem_addr", mem_addr, {addr[31:5], 5'b0});
    check("miss_ready_busy", miss_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      mem_resp  = 1'b1;
      mem_rdata = base + 64'(k);
      @(posedge clk); #1;
      mem_resp  = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (k < 3) repeat (gap) begin @(posedge clk); #1; end
    end
    check("mem_read_drop", mem_read, 1'b0);
    check("state_write", fsm_state, 2'd2);
    n = 0;
    while (!fill_done && n < 50) begin @(posedge clk); #1; n++; end
    check("fill_done", fill_done, 1'b1);
    check("fill_latency", cyc - last_acc, 6 + 3 * gap);
`ifdef ICACHE_FILL_BYPASS_EN
    check("bypass_valid", bypass_valid, 1'b1);
    check("bypass_line", bypass_line, line);
`else
    check("bypass_valid_off", bypass_valid, 1'b0);
`endif
    last_done = cyc;
    if (stray_done) begin
      mem_resp  = 1'b1;
      mem_rdata = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    mem_resp = 1'b0;
    check("fill_done_pulse", fill_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_miss_ready", miss_ready, 1'b1);
    check("rst_fill_done", fill_done, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_csb", sram_csb0, 1'b1);
    check("rst_web", sram_web0, 1'b1);
    check("rst_wmask", sram_wmask0, 32'h0);
    check("rst_din", sram_din0, 256'h0);
    check("rst_tag_we", tag_we, 1'b0);
    check("rst_tag_wdata", tag_wdata, 23'h0);
    check("rst_bypass", bypass_valid, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic fill, then gapped beats with a stray beat in DONE
    do_fill(32'h1234_56A0, 64'h0, 0, 1'b0, 1'b0);
    check("basic_tag_hand", {9'h0, 23'h091A2B}, {9'h0, 32'h1234_56A0 >> 9});
    do_fill(32'hCAFE_F1E4, 64'h1111_0000_0000_0000, 2, 1'b0, 1'b1);

    // stray beats while idle must not move the beat counter
    mem_resp = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    repeat (2) begin @(posedge clk); #1; end
    mem_resp = 1'b0;
    check("idle_no_read", mem_read, 1'b0);
    do_fill(32'h0000_0040, 64'h2222_0000_0000_0000, 0, 1'b0, 1'b0);

    // back-to-back: request held high through the first fill
    do_fill(32'h0000_0060, 64'h3333_0000_0000_0000, 0, 1'b1, 1'b0);
    begin
      int done1;
      done1 = last_done;
      do_fill(32'hDEAD_BE80, 64'h4444_0000_0000_0000, 1, 1'b0, 1'b0);
      check("b2b_accept_gap", last_acc - done1, 1);
    end

    // reset after two beats
    miss_addr = 32'h0000_0100; miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_resp = 1'b1; mem_rdata = 64'h5555_0000_0000_0000 + 64'(k);
      @(posedge clk); #1;
    end
    mem_resp = 1'b0;
    check("pre_rst_mem_read", mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_read", mem_read, 1'b0);
    check("rst_mid_csb", sram_csb0, 1'b1);
    check("rst_mid_tag_we", tag_we, 1'b0);
    check("rst_mid_miss_ready", miss_ready, 1'b1);
    check("rst_mid_mem_addr", mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_fill(32'h0000_0140, 64'h6666_0000_0000_0000, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("set5_line", sram_mem[5], {64'h3, 64'h2, 64'h1, 64'h0});
    check("set3_line", sram_mem[3], {64'h3333_0000_0000_0003, 64'h3333_0000_0000_0002,
                                     64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000});
    check("set4_line", sram_mem[4], {64'h4444_0000_0000_0003, 64'h4444_0000_0000_0002,
                                     64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000});
    check("write_count", n_wr, 6);
    check("pending_left", exp_q.size(), 0);
`ifdef ICACHE_FILL_BYPASS_EN
    check("bypass_seen", bp_seen, 1'b1);
`else
    check("bypass_never", bp_seen, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
